// File: rtl/rect_fill_engine.sv
// Datapath responder for the paint controller: latches corners and colour, then emits one
// pixel per cycle, either scanning a filled rectangle or tracking a freeform point.
module rect_fill_engine #(
  parameter int unsigned X_W   = 8,
  parameter int unsigned Y_W   = 7,
  parameter int unsigned C_W   = 3,
  parameter int unsigned X_MAX = 159,
  parameter int unsigned Y_MAX = 119
) (
  input  logic           Clock,
  input  logic           reset_N,
  input  logic [X_W-1:0] data_in,
  input  logic [C_W-1:0] colour_in,
  input  logic           loadX,
  input  logic           loadY,
  input  logic           loadX2,
  input  logic           loadY2,
  input  logic           loadC,
  input  logic           enable,
  input  logic [1:0]     alu_select,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic [C_W-1:0] colour_out,
  output logic           plot,
  output logic           doneSq
);

  localparam logic [X_W-1:0] XLim = X_W'(X_MAX);
  localparam logic [Y_W-1:0] YLim = Y_W'(Y_MAX);

  typedef enum logic [2:0] {StIdle, StSetup, StScan, StDone, StFree} state_e;

  state_e state_q, state_d;

  logic [X_W-1:0] x1_q, x2_q, cx_q, xs_q, xe_q;
  logic [Y_W-1:0] y1_q, y2_q, cy_q, ys_q, ye_q;
  logic [C_W-1:0] colour_q;

  logic [X_W-1:0] x_clamp, x_lo, x_hi;
  logic [Y_W-1:0] y_raw, y_clamp, y_lo, y_hi;
  logic           last_pixel;

  assign y_raw   = data_in[Y_W-1:0];
  assign x_clamp = (data_in > XLim) ? XLim : data_in;
  assign y_clamp = (y_raw > YLim) ? YLim : y_raw;

  assign x_lo = (x1_q <= x2_q) ? x1_q : x2_q;
  assign x_hi = (x1_q <= x2_q) ? x2_q : x1_q;
  assign y_lo = (y1_q <= y2_q) ? y1_q : y2_q;
  assign y_hi = (y1_q <= y2_q) ? y2_q : y1_q;

  assign last_pixel = (cx_q == xe_q) && (cy_q == ye_q);

  // Corner and colour registers load in every state, independently of the FSM.
  always_ff @(posedge Clock or posedge reset_N) begin
    if (reset_N) begin
      x1_q     <= '0;
      y1_q     <= '0;
      x2_q     <= '0;
      y2_q     <= '0;
      colour_q <= '0;
    end else begin
      if (loadX)  x1_q     <= x_clamp;
      if (loadY)  y1_q     <= y_clamp;
      if (loadX2) x2_q     <= x_clamp;
      if (loadY2) y2_q     <= y_clamp;
      if (loadC)  colour_q <= colour_in;
    end
  end

  // Bounds are snapshotted in SETUP so corner loads during a fill cannot disturb it.
  always_ff @(posedge Clock or posedge reset_N) begin
    if (reset_N) begin
      xs_q <= '0;
      xe_q <= '0;
      ys_q <= '0;
      ye_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      unique case (state_q)
        StSetup: begin
          xs_q <= x_lo;
          xe_q <= x_hi;
          ys_q <= y_lo;
          ye_q <= y_hi;
          cx_q <= x_lo;
          cy_q <= y_lo;
        end
        StScan: begin
          if (enable && !last_pixel) begin
            if (cx_q != xe_q) begin
              cx_q <= cx_q + 1'b1;
            end else begin
              cx_q <= xs_q;
              cy_q <= cy_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge reset_N) begin
    if (reset_N) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (enable && alu_select == 2'b01)      state_d = StSetup;
        else if (enable && alu_select == 2'b11) state_d = StFree;
      end
      StSetup: state_d = enable ? StScan : StIdle;
      StScan: begin
        if (!enable)        state_d = StIdle;
        else if (last_pixel) state_d = StDone;
      end
      StDone:  if (!enable) state_d = StIdle;
      StFree:  if (!enable || alu_select != 2'b11) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    plot   = 1'b0;
    doneSq = 1'b0;
    x_out  = '0;
    y_out  = '0;
    unique case (state_q)
      StScan: begin
        plot  = 1'b1;
        x_out = cx_q;
        y_out = cy_q;
      end
      StFree: begin
        plot  = 1'b1;
        x_out = x1_q;
        y_out = y1_q;
      end
      StDone:  doneSq = 1'b1;
      default: ;
    endcase
  end

  assign colour_out = colour_q;

endmodule

// File: doc/rect_fill_engine.md
Name: rect_fill_engine

Overview:
- Datapath-side responder to the paint drawing controller.
- Consumes the controller's load strobes (loadX, loadY, loadX2, loadY2, loadC), enable and alu_select.
- Latches corner coordinates and colour. Emits one VGA pixel (x, y, colour, plot) per cycle, either scanning a filled rectangle or plotting freeform points.
- Returns doneSq to the controller when a rectangle fill completes.

Parameters:
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- C_W, 3, colour width.
- X_MAX, 159, largest legal x; larger loads clamp to this.
- Y_MAX, 119, largest legal y; larger loads clamp to this.

Ports:
- Clock  input  1  system clock, rising edge.
- reset_N  input  1  asynchronous, active-high reset.
- data_in  input  X_W  coordinate source from the switches. y loads use data_in[Y_W-1:0].
- colour_in  input  C_W  colour source.
- loadX, loadY, loadX2, loadY2  input  1 each  coordinate register load strobes.
- loadC  input  1  colour register load strobe.
- enable  input  1  drawing request from the controller.
- alu_select  input  2  operation: 00 idle, 01 rectangle fill, 11 freeform, 10 reserved (treated as idle).
- x_out  output  X_W  pixel x.
- y_out  output  Y_W  pixel y.
- colour_out  output  C_W  pixel colour.
- plot  output  1  pixel write strobe.
- doneSq  output  1  rectangle-complete flag.

Behaviour:
- Reset (async, high): x1, y1, x2, y2, colour, cx, cy and bounds all go to 0; state IDLE. Outputs on reset: plot=0, doneSq=0, x_out=0, y_out=0, colour_out=0.
- Load registers:
  - On a rising edge, each strobe loads its register independently and simultaneous strobes are all honoured.
  - x values above X_MAX clamp to X_MAX; y values above Y_MAX clamp to Y_MAX.
  - loadC loads colour from colour_in.
  - Loads are accepted in every state. A loaded value is visible the following cycle.
- colour_out always equals the colour register. Colour is frozen during a fill because the controller drops loadC there.
- FSM states: IDLE, SETUP, SCAN, DONE, FREE.
- IDLE:
  - plot=0, doneSq=0.
  - enable && alu_select==01 -> SETUP.
  - enable && alu_select==11 -> FREE.
  - Otherwise stay in IDLE.
- SETUP (one cycle):
  - xs=min(x1,x2), xe=max(x1,x2), ys=min(y1,y2), ye=max(y1,y2).
  - cx=xs, cy=ys.
  - -> SCAN.
  - Bounds are latched here; later loads do not affect the fill in progress.
- SCAN:
  - plot=1, x_out=cx, y_out=cy (driven from registers).
  - Each cycle: if cx!=xe then cx++. Else cx=xs and cy++.
  - When cx==xe && cy==ye (last pixel) -> DONE.
  - Row-major order, exactly (xe-xs+1)*(ye-ys+1) plot cycles.
  - Degenerate cases: a single pixel gives 1 plot cycle; a line gives a single row or column.
- DONE:
  - plot=0, doneSq=1.
  - Hold while enable=1; enable=0 -> IDLE and doneSq drops that edge.
  - doneSq stays high for as many cycles as the controller needs to register it.
- FREE:
  - plot=1, x_out=x1, y_out=y1, every cycle.
  - The controller strobes loadX/loadY continuously, so the point tracks data_in with one cycle of lag.
  - doneSq=0.
  - Leave to IDLE when enable=0 or alu_select!=11.
- Abort: enable=0 in SETUP or SCAN -> IDLE next edge, plot=0, no doneSq. A fill aborted this way never resumes; the next request restarts from SETUP.
- Latency: enable seen in IDLE on edge k, SETUP at k+1, first plot cycle starting k+2. doneSq rises the edge after the last plot cycle.
- alu_select changing mid-SCAN is ignored; only enable aborts.
- Reset asserted mid-operation forces IDLE immediately and clears plot and doneSq asynchronously.
- Counter width rules:
  - cx is X_W bits and cy is Y_W bits; neither wraps, since the comparison to xe/ye ends the scan.
  - Clamping guarantees xe<=X_MAX and ye<=Y_MAX.

Test Plan:
- Reset: with loads toggling and enable=1, assert reset_N mid-SCAN -> plot=0, doneSq=0, x_out=y_out=0 immediately; after release, the FSM is in IDLE.
- Fill: corners (2,3) and (4,4), colour 3'b101, enable with alu_select=01 -> exactly 6 plot cycles: (2,3)(3,3)(4,3)(2,4)(3,4)(4,4), colour_out=101 throughout. Then doneSq=1, held until enable drops.
- Reversed corners (4,4) and (2,3) -> identical 6-pixel sequence. Single-pixel corners (7,7) and (7,7) -> one plot at (7,7), then doneSq.
- Abort: fill (0,0)-(9,9), drop enable after 5 plot cycles -> plot=0 next cycle, doneSq never asserts. A new request then restarts at (0,0).
- Freeform: alu_select=11, enable=1, loadX/loadY high, data_in stepping 10, 11, 12 -> plot=1 each cycle with x_out following with one cycle of lag. Dropping enable gives plot=0 next cycle.
- Clamp and independence: load x=200, y=127 -> stored as 159 and 119. Strobing loadX2 during SCAN does not change the remaining pixel sequence.
